riscv_mini_sequencer: RTL and testbench

Program sequencer for the 8-bit RISC-V-Mini core. It holds a small program in an on-chip instruction buffer, loaded one byte at a time. On start it issues one 16-bit instruction per cycle to the core's instruction input. It also supports a skip-next branch on compare results and captures the core's 8-bit result for every output-class instruction. It sits between the chip pins and the core, replacing direct pin-driven instruction entry.

---
 rtl/riscv_mini_sequencer.sv | 136 +++++++++++++
 tb/tb_riscv_mini_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mini_sequencer.sv
// Program sequencer for the 8-bit RISC-V-Mini core: byte-wise program load into a small
// instruction buffer, then one instruction per cycle with compare-driven skip and result capture.
module riscv_mini_sequencer #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    input  logic          start,
    input  logic [7:0]    core_result,
    output logic [15:0]   instr_out,
    output logic          instr_valid,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   prog_len,
    output logic          load_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [15:0] NOP  = 16'h0002;
    localparam logic [15:0] HALT = 16'hFFFF;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t       state_q, state_d;
    logic [15:0]  mem [DEPTH];
    logic [AW:0]  pc, wr_ptr, fetch_addr;
    logic [7:0]   low_byte;
    logic         phase;
    logic         skip, fetch_end, mem_we;
    logic [15:0]  fetch_word;

    // The skip decision looks at the compare still on instr_out, so the fetch address is
    // resolved in the same cycle with no bubble.
    assign skip       = instr_valid && (instr_out[1:0] == 2'b11) &&
                        (instr_out[15:13] == 3'b011) && core_result[0];
    assign fetch_addr = pc + {{AW{1'b0}}, skip};
    assign fetch_word = mem[fetch_addr[AW-1:0]];
    assign fetch_end  = (fetch_addr >= prog_len) || (fetch_word == HALT);
    assign mem_we     = (state_q == S_LOAD) && load_en && load_valid && phase && (wr_ptr != FULL);

    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_en)    state_d = S_LOAD;
                else if (start) state_d = (prog_len == '0) ? S_DONE : S_RUN;
            end
            S_LOAD:  if (!load_en)  state_d = S_IDLE;
            S_RUN:   if (fetch_end) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_LOAD) || (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // NOTE: the instruction buffer has no reset; it is plain RAM and its contents survive runs.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= {load_byte, low_byte};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_out   <= NOP;
            instr_valid <= 1'b0;
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            prog_len    <= '0;
            load_err    <= 1'b0;
            pc          <= '0;
            wr_ptr      <= '0;
            phase       <= 1'b0;
            low_byte    <= 8'h00;
        end else begin
            out_valid <= 1'b0;
            if (instr_valid && (instr_out[1:0] == 2'b11)) begin
                out_data  <= core_result;
                out_valid <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (load_en) begin
                        wr_ptr   <= '0;
                        phase    <= 1'b0;
                        load_err <= 1'b0;
                    end else if (start) begin
                        pc <= '0;
                    end
                end
                S_LOAD: begin
                    if (!load_en) begin
                        prog_len <= wr_ptr;
                        phase    <= 1'b0;
                    end else if (load_valid) begin
                        if (wr_ptr == FULL) begin
                            load_err <= 1'b1;
                        end else if (!phase) begin
                            low_byte <= load_byte;
                            phase    <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + ONE;
                            phase  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (fetch_end) begin
                        instr_out   <= NOP;
                        instr_valid <= 1'b0;
                    end else begin
                        instr_out   <= fetch_word;
                        instr_valid <= 1'b1;
                        pc          <= fetch_addr + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mini_sequencer.sv
// Self-checking bench for riscv_mini_sequencer: directed and randomized programs checked
// against an instruction-level interpreter of the sequencer's load/run rules.
module tb_riscv_mini_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [15:0] NOP  = 16'h0002;
    localparam logic [15:0] HALT = 16'hFFFF;

    logic          clk = 1'b0;
    logic          rst, load_en, load_valid, start;
    logic [7:0]    load_byte, core_result;
    logic [15:0]   instr_out;
    logic          instr_valid, out_valid, busy, done, load_err;
    logic [7:0]    out_data;
    logic [AW:0]   prog_len;

    riscv_mini_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid),
        .load_byte(load_byte), .start(start), .core_result(core_result),
        .instr_out(instr_out), .instr_valid(instr_valid), .out_data(out_data),
        .out_valid(out_valid), .busy(busy), .done(done), .prog_len(prog_len),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: program image, length and overflow flag.
    logic [7:0]  bytes_q[$];
    logic [15:0] m_mem [DEPTH];
    int          m_len;
    logic        m_err;
    logic        force_en;
    logic [7:0]  force_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bytes(input string tag);
        int n;
        load_en = 1'b1;
        tick();
        foreach (bytes_q[i]) begin
            load_valid = 1'b1;
            load_byte  = bytes_q[i];
            tick();
        end
        load_valid = 1'b0;
        n     = bytes_q.size();
        m_len = (n / 2 > DEPTH) ? DEPTH : n / 2;
        for (int i = 0; i < m_len; i++) m_mem[i] = {bytes_q[2*i+1], bytes_q[2*i]};
        m_err = (n > 2 * DEPTH);
        check({tag, "_load_err"}, load_err, m_err);
        check({tag, "_busy_load"}, busy, 1);
        load_en = 1'b0;
        tick();
        check({tag, "_prog_len"}, prog_len, m_len);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic push_word(input logic [15:0] w);
        bytes_q.push_back(w[7:0]);
        bytes_q.push_back(w[15:8]);
    endtask

    task automatic run_prog(input string tag);
        int          mpc;
        bit          pend, fin;
        logic [7:0]  r, pr;
        logic [15:0] w;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_len == 0) begin
            check({tag, "_empty_done"}, done, 1);
            check({tag, "_empty_valid"}, instr_valid, 0);
            return;
        end
        check({tag, "_first_nop"}, instr_valid, 0);
        mpc = 0; pend = 0; fin = 0; pr = 8'h00;
        for (int c = 0; c < DEPTH + 4 && !fin; c++) begin
            tick();
            check({tag, "_out_valid"}, out_valid, pend);
            if (pend) check({tag, "_out_data"}, out_data, pr);
            if (mpc >= m_len || m_mem[mpc] == HALT) begin
                check({tag, "_done"}, done, 1);
                check({tag, "_end_valid"}, instr_valid, 0);
                check({tag, "_end_nop"}, instr_out, NOP);
                check({tag, "_end_busy"}, busy, 0);
                fin = 1;
            end else begin
                w = m_mem[mpc];
                check({tag, "_instr"}, instr_out, w);
                check({tag, "_valid"}, instr_valid, 1);
                check({tag, "_busy"}, busy, 1);
                r  = force_en ? force_val : 8'($urandom);
                core_result = r;
                pr   = r;
                pend = (w[1:0] == 2'b11);
                mpc += (pend && w[15:13] == 3'b011 && r[0]) ? 2 : 1;
            end
        end
        if (!fin) check({tag, "_timeout"}, 0, 1);
        tick();
        check({tag, "_post_out_valid"}, out_valid, 0);
        check({tag, "_post_done"}, done, 1);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
        start = 1'b0; core_result = 8'h00; force_en = 1'b0; force_val = 8'h00;
        m_len = 0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr", instr_out, NOP);
        check("rst_valid", instr_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_prog_len", prog_len, 0);
        check("rst_load_err", load_err, 0);
        rst = 1'b0;
        tick();

        // load_en wins over start in the same cycle.
        load_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("prio_busy", busy, 1);
        check("prio_done", done, 0);
        check("prio_valid", instr_valid, 0);
        load_en = 1'b0;
        tick();
        check("prio_len", prog_len, 0);

        // Two-instruction program.
        bytes_q = '{8'h41, 8'h20, 8'h02, 8'hFF};
        load_bytes("basic");
        run_prog("basic");

        // Compare/skip program: load imm, compare, X, output.
        bytes_q.delete();
        push_word(16'h1001); push_word(16'h6003); push_word(16'h1235); push_word(16'h8003);
        load_bytes("cmp");
        force_en = 1'b1;
        force_val = 8'h01; run_prog("cmp_skip");
        force_val = 8'h00; run_prog("cmp_noskip");
        force_val = 8'hA5; run_prog("cmp_a5");
        force_en = 1'b0;

        // HALT at entry 1 of a four-entry program.
        bytes_q.delete();
        push_word(16'h1003); push_word(HALT); push_word(16'h1002); push_word(16'h1007);
        load_bytes("halt");
        run_prog("halt");

        // Randomized programs, sometimes with a dangling low byte or an embedded HALT.
        for (int t = 0; t < 12; t++) begin
            int n;
            logic [15:0] w;
            bytes_q.delete();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                case ($urandom_range(0, 4))
                    0: w = {3'b011, w[12:2], 2'b11};
                    1: w = {w[15:2], 2'b11};
                    2: w = {w[15:2], 2'b01};
                    3: if ($urandom_range(0, 5) == 0) w = HALT;
                    default: ;
                endcase
                push_word(w);
            end
            if ($urandom_range(0, 2) == 0) bytes_q.push_back(8'($urandom));
            load_bytes("rand");
            run_prog("rand");
            if (t % 4 == 3) run_prog("rerun");
        end

        // Overflow: 2*DEPTH+2 bytes, then re-entering LOAD clears the flag.
        bytes_q.delete();
        for (int i = 0; i < 2 * DEPTH + 2; i++) bytes_q.push_back(8'($urandom));
        load_bytes("ovf");
        bytes_q.delete();
        load_bytes("reload");
        run_prog("empty");

        // Reset in the middle of a run.
        bytes_q.delete();
        for (int i = 0; i < 8; i++) push_word(16'h1001 + 16'(i << 4));
        load_bytes("mid");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_len", prog_len, 0);
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_done", done, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", instr_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
